// File: rtl/aes_inv_round_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the iterative AES-128 decryption controller:
//   - state_t      : controller FSM states
//   - AES_BLOCK_W  : block width in bits
//   - NR           : number of AES-128 rounds
//   - INV_SBOX     : 256-entry inverse S-box
//   - gf_mul       : GF(2^8) multiply, reduction polynomial 0x11B
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int NR          = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Shift-and-add multiply; with a constant b this collapses to a few XORs.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_inv_round_ctrl_if
// Bundles the request, key-store and response signals of the decryption
// controller.
//   in_valid/in_ready/in_data    : ciphertext request handshake
//   rk_idx/rk_data               : round-key index out, key back same cycle
//   out_valid/out_ready/out_data : plaintext response handshake
//   busy                         : controller not idle
// Modports: slave = controller side, master = environment side.
// ---------------------------------------------------------------------------
interface aes_inv_round_ctrl_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_BLOCK_W-1:0] in_data;
  logic [3:0]             rk_idx;
  logic [AES_BLOCK_W-1:0] rk_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_BLOCK_W-1:0] out_data;
  logic                   busy;

  modport slave (
    input  in_valid, in_data, rk_data, out_ready,
    output in_ready, rk_idx, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, rk_data, out_ready,
    input  in_ready, rk_idx, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_inv_round_ctrl_round.sv
// ---------------------------------------------------------------------------
// aes_inv_round
// Purely combinational AES inverse round:
//   invShiftRow -> invSubBytes -> AddRoundKey -> invMixColumns
// invMixColumns is bypassed when i_last_round is high.
// Ports:
//   i_state      : 128-bit state, byte 0 at [127:120], column-major
//   i_rk         : round key for this round
//   i_last_round : 1 = final round (no invMixColumns)
//   o_state      : next state
// ---------------------------------------------------------------------------
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] i_state,
  input  logic [AES_BLOCK_W-1:0] i_rk,
  input  logic                   i_last_round,
  output logic [AES_BLOCK_W-1:0] o_state
);

  logic [AES_BLOCK_W-1:0] w_sub;
  logic [AES_BLOCK_W-1:0] w_ark;
  logic [AES_BLOCK_W-1:0] w_mix;

  // Byte gi sits at row gi%4, column gi/4. invShiftRow is pure wiring:
  // output (r,c) takes input (r,(c-r) mod 4), then goes through the S-box.
  for (genvar gi = 0; gi < 16; gi++) begin : g_sub
    localparam int COL = gi / 4;
    localparam int ROW = gi % 4;
    localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
    assign w_sub[127-8*gi -: 8] = INV_SBOX[i_state[127-8*SRC -: 8]];
  end

  assign w_ark = w_sub ^ i_rk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_ark[127-32*gi -: 8];
    assign w_a1 = w_ark[119-32*gi -: 8];
    assign w_a2 = w_ark[111-32*gi -: 8];
    assign w_a3 = w_ark[103-32*gi -: 8];
    assign w_mix[127-32*gi -: 8] = gf_mul(w_a0, 8'h0e) ^ gf_mul(w_a1, 8'h0b)
                                 ^ gf_mul(w_a2, 8'h0d) ^ gf_mul(w_a3, 8'h09);
    assign w_mix[119-32*gi -: 8] = gf_mul(w_a0, 8'h09) ^ gf_mul(w_a1, 8'h0e)
                                 ^ gf_mul(w_a2, 8'h0b) ^ gf_mul(w_a3, 8'h0d);
    assign w_mix[111-32*gi -: 8] = gf_mul(w_a0, 8'h0d) ^ gf_mul(w_a1, 8'h09)
                                 ^ gf_mul(w_a2, 8'h0e) ^ gf_mul(w_a3, 8'h0b);
    assign w_mix[103-32*gi -: 8] = gf_mul(w_a0, 8'h0b) ^ gf_mul(w_a1, 8'h0d)
                                 ^ gf_mul(w_a2, 8'h09) ^ gf_mul(w_a3, 8'h0e);
  end

  assign o_state = i_last_round ? w_ark : w_mix;

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_inv_round_ctrl
// Iterative AES-128 decryption controller, one inverse round per clock.
// Accept -> 9 ROUND cycles -> 1 FINAL cycle -> DONE until the plaintext is
// taken. Latency accept-to-out_valid is 11 cycles, initiation interval 12.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : request/key/response interface (slave side)
// Parameter NR: number of rounds, only 10 is supported.
// ---------------------------------------------------------------------------
module aes_inv_round_ctrl #(
  parameter int NR = 10
) (
  input logic                 clk,
  input logic                 rst,
  aes_inv_round_ctrl_if.slave bus
);
  import aes_pkg::*;

  state_t                 r_fsm;
  state_t                 w_fsm_next;
  logic [3:0]             r_rnd;
  logic [AES_BLOCK_W-1:0] r_block;
  logic [AES_BLOCK_W-1:0] w_round_out;
  logic                   w_last_round;
  logic                   w_accept;

  assign w_accept = (r_fsm == IDLE) && bus.in_valid;

  aes_inv_round u_round (
    .i_state      (r_block),
    .i_rk         (bus.rk_data),
    .i_last_round (w_last_round),
    .o_state      (w_round_out)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_next;
  end

  // Next-state logic
  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      IDLE:    if (bus.in_valid)  w_fsm_next = ROUND;
      ROUND:   if (r_rnd == 4'd1) w_fsm_next = FINAL;
      FINAL:                      w_fsm_next = DONE;
      DONE:    if (bus.out_ready) w_fsm_next = IDLE;
      default:                    w_fsm_next = IDLE;
    endcase
  end

  // Outputs depend on registered state only, so in_ready/out_valid have no
  // combinational path from in_valid/out_ready.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    bus.rk_idx    = r_rnd;
    w_last_round  = 1'b0;
    case (r_fsm)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        bus.rk_idx   = 4'(NR);
      end
      ROUND:   w_last_round = 1'b0;
      FINAL:   w_last_round = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: bus.busy = 1'b1;
    endcase
  end

  assign bus.out_data = r_block;

  // Round counter and data state. rnd leaves ROUND at 1 and goes to 0, so
  // the decrement never wraps; in DONE it sits at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rnd   <= 4'd0;
      r_block <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (w_accept) begin
            r_rnd   <= 4'(NR - 1);
            r_block <= bus.in_data ^ bus.rk_data;
          end
        end
        ROUND: begin
          r_rnd   <= r_rnd - 4'd1;
          r_block <= w_round_out;
        end
        FINAL:   r_block <= w_round_out;
        default: r_block <= r_block;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_round_ctrl
// Scoreboard bench: accepted blocks push their expected plaintext, a
// negedge monitor checks the handshake/rk_idx timing against a cycle-count
// model and pops results when the DUT hands them over. The reference cipher
// builds its own S-box from GF(2^8) inversion plus the affine map.
// ---------------------------------------------------------------------------
module tb_aes_inv_round_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_inv_round_ctrl_if bus_if ();

  aes_inv_round_ctrl #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [127:0] rk_mem [16];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_k = 0;          // 0 idle, 1..10 cycles since accept, 11 result held
  int acc_count = 0;
  int acc_log [$];
  logic [127:0] sb_q [$];
  bit chk_on = 0;
  bit rst_last = 0;
  bit kat_mode = 0;
  bit rand_ready = 0;

  assign bus_if.rk_data = rk_mem[bus_if.rk_idx];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 0;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sb[x] = s;
      isb[s] = 8'(x);
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_mem[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Textbook inverse cipher over a 16-byte array (index = 4*col + row).
  function automatic logic [127:0] ref_dec(input logic [127:0] ct);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] blk;
    blk = ct ^ rk_mem[10];
    for (int r = 9; r >= 0; r--) begin
      for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c+w] = isb[s[4*((c-w+4)%4)+w]];
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = t[i];
      blk = blk ^ rk_mem[r];
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
        for (int c = 0; c < 4; c++) begin
          t[4*c]   = gmul(s[4*c],8'h0e)^gmul(s[4*c+1],8'h0b)^gmul(s[4*c+2],8'h0d)^gmul(s[4*c+3],8'h09);
          t[4*c+1] = gmul(s[4*c],8'h09)^gmul(s[4*c+1],8'h0e)^gmul(s[4*c+2],8'h0b)^gmul(s[4*c+3],8'h0d);
          t[4*c+2] = gmul(s[4*c],8'h0d)^gmul(s[4*c+1],8'h09)^gmul(s[4*c+2],8'h0e)^gmul(s[4*c+3],8'h0b);
          t[4*c+3] = gmul(s[4*c],8'h0b)^gmul(s[4*c+1],8'h0d)^gmul(s[4*c+2],8'h09)^gmul(s[4*c+3],8'h0e);
        end
        for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = t[i];
      end
    end
    return blk;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d timeout", name, cyc);
  endtask

  // Monitor / scoreboard: compare what the DUT shows this cycle, then
  // decide what the coming rising edge will do.
  always @(negedge clk) begin
    cyc++;
    if (chk_on) begin
      chk("in_ready",  128'(bus_if.in_ready),  128'(m_k == 0));
      chk("busy",      128'(bus_if.busy),      128'(m_k != 0));
      chk("out_valid", 128'(bus_if.out_valid), 128'(m_k == 11));
      if (m_k <= 10)
        chk("rk_idx", 128'(bus_if.rk_idx), 128'((m_k == 0) ? 10 : (m_k <= 9 ? 10 - m_k : 0)));
      if (rst_last) chk("out_data_reset", bus_if.out_data, 128'h0);
      if (m_k == 11) begin
        if (sb_q.size() == 0) fail_now("scoreboard_empty");
        else chk("out_data", bus_if.out_data, sb_q[0]);
      end
    end
    rst_last = rst;
    if (rst) begin
      chk_on = 1;
      m_k = 0;
      sb_q.delete();
    end else if (m_k == 0) begin
      if (bus_if.in_valid) begin
        sb_q.push_back(kat_mode ? FIPS_PT : ref_dec(bus_if.in_data));
        acc_count++;
        acc_log.push_back(cyc);
        $display("ACCEPT cyc=%0d ct=%h", cyc, bus_if.in_data);
        m_k = 1;
      end
    end else if (m_k <= 10) begin
      m_k++;
    end else if (bus_if.out_ready) begin
      $display("OUTPUT cyc=%0d pt=%h", cyc, bus_if.out_data);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
      m_k = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) bus_if.out_ready = ($urandom_range(0, 1) == 1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a block and return in the cycle after it was accepted.
  task automatic send(input logic [127:0] ct);
    int start = acc_count;
    int n = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = ct;
    while (acc_count == start && n < 100) begin
      step();
      n++;
    end
    bus_if.in_valid = 1'b0;
    if (acc_count == start) fail_now("send");
  endtask

  task automatic wait_done();
    int n = 0;
    while (m_k != 11 && n < 100) begin
      step();
      n++;
    end
    if (m_k != 11) fail_now("wait_done");
  endtask

  task automatic drain();
    int n = 0;
    while ((m_k != 0 || sb_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    if (m_k != 0 || sb_q.size() != 0) fail_now("drain");
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int a0;
    rst = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
    build_sbox();
    set_key(FIPS_KEY);
    repeat (3) step();
    rst = 1'b0;
    step();

    // FIPS-197 known answer, free-flowing output
    kat_mode = 1;
    bus_if.out_ready = 1'b1;
    send(FIPS_CT);
    drain();

    // Backpressure: hold the result 5 cycles
    bus_if.out_ready = 1'b0;
    send(FIPS_CT);
    wait_done();
    repeat (5) step();
    bus_if.out_ready = 1'b1;
    drain();

    // All-ones requests offered while busy (T+3..T+8) must be ignored
    send(FIPS_CT);          // now in T+1
    repeat (2) step();
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = '1;
    repeat (6) step();
    bus_if.in_valid = 1'b0;
    drain();

    // Reset at T+5 aborts the block; next block still decrypts
    send(FIPS_CT);
    repeat (4) step();
    pulse_rst();
    repeat (15) step();
    send(FIPS_CT);
    drain();

    // Back-to-back: second accept exactly 12 cycles after the first
    acc_log.delete();
    bus_if.out_ready = 1'b1;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = FIPS_CT;
    for (int n = 0; n < 60 && acc_log.size() < 2; n++) step();
    bus_if.in_valid = 1'b0;
    if (acc_log.size() < 2) fail_now("b2b_accepts");
    else begin
      a0 = acc_log[0];
      chk("b2b_interval", 128'(acc_log[1] - a0), 128'(12));
    end
    drain();

    // Reset while holding a result with out_ready low
    bus_if.out_ready = 1'b0;
    send(FIPS_CT);
    wait_done();
    repeat (2) step();
    pulse_rst();
    repeat (3) step();
    bus_if.out_ready = 1'b1;
    drain();

    // Random keys, ciphertexts, gaps and output stalls
    kat_mode = 0;
    for (int k = 0; k < 4; k++) begin
      set_key({$urandom, $urandom, $urandom, $urandom});
      rand_ready = 1;
      for (int b = 0; b < 15; b++) begin
        repeat ($urandom_range(0, 3)) step();
        send({$urandom, $urandom, $urandom, $urandom});
      end
      drain();
      rand_ready = 0;
      bus_if.out_ready = 1'b1;
    end

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
